// File: rtl/cga_pkg.sv
// Shared CRTC constants: I/O port addresses, register indices, reset values
// and the register readback/status helpers.
package cga_pkg;

    localparam logic [15:0] ADDR_INDEX  = 16'h03D4;
    localparam logic [15:0] ADDR_DATA   = 16'h03D5;
    localparam logic [15:0] ADDR_STATUS = 16'h03DA;

    localparam logic [4:0] IDX_CS = 5'h0A;
    localparam logic [4:0] IDX_CE = 5'h0B;
    localparam logic [4:0] IDX_CH = 5'h0E;
    localparam logic [4:0] IDX_CL = 5'h0F;

    localparam logic [4:0] RST_INDEX  = 5'h00;
    localparam logic [5:0] RST_CS     = 6'h0E;
    localparam logic [4:0] RST_CE     = 5'h0F;
    localparam logic [2:0] RST_CH     = 3'h0;
    localparam logic [7:0] RST_CL     = 8'h00;
    localparam logic [7:0] RST_PORT_O = 8'h00;

    typedef struct packed {
        logic [5:0] cs;
        logic [4:0] ce;
        logic [2:0] ch;
        logic [7:0] cl;
    } crtc_regs_t;

    localparam crtc_regs_t REGS_RESET = '{cs: RST_CS, ce: RST_CE, ch: RST_CH, cl: RST_CL};

    function automatic logic [7:0] reg_read(input crtc_regs_t r, input logic [4:0] idx);
        logic [7:0] v;
        case (idx)
            IDX_CS:  v = {2'b00, r.cs};
            IDX_CE:  v = {3'b000, r.ce};
            IDX_CH:  v = {5'b00000, r.ch};
            IDX_CL:  v = r.cl;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Retrace bit 0 is also forced during vertical sync.
    function automatic logic [7:0] status_byte(input logic vs_q, input logic hs_q);
        return {4'b0000, vs_q, 2'b00, (~hs_q | vs_q)};
    endfunction

endpackage

// File: rtl/cga_sync_edge.sv
// Registers one sync input and produces a one-cycle pulse in the cycle after
// the registered copy rises.
module cga_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic q_q, q_d;
    logic rise_q, rise_d;

    // Next state: sample the input, flag a low-to-high transition of q.
    always_comb begin
        q_d    = d_i;
        rise_d = d_i & ~q_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q    <= RESET_VAL;
            rise_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
        end
    end

    assign q_o    = q_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/cga_crtc.sv
// CGA CRTC register subset: index/data ports, status port, cursor outputs.
// Define CRTC_VSYNC_LATCH_EN to make outputs update only at vertical sync.
module cga_crtc
    import cga_pkg::*;
(
    input  logic        clock_25,
    input  logic        reset,
    input  logic [15:0] port_a,
    input  logic [7:0]  port_i,
    input  logic        port_w,
    input  logic        port_r,
    output logic [7:0]  port_o,
    output logic        port_sel,
    input  logic        hs,
    input  logic        vs,
    output logic [10:0] cursor,
    output logic [5:0]  cursor_shape_lo,
    output logic [4:0]  cursor_shape_hi
);

    logic [4:0] index_q, index_d;
    crtc_regs_t regs_q, regs_d;
    crtc_regs_t out_s;
    logic [7:0] port_o_q, port_o_d;
    logic       hs_q, vs_q, vs_rise;
    logic       hs_rise_unused;
    logic       is_index_s, is_data_s, is_status_s;

    cga_sync_edge #(.RESET_VAL(1'b1)) u_hs_sync (
        .clk_i(clock_25), .reset_i(reset), .d_i(hs), .q_o(hs_q), .rise_o(hs_rise_unused)
    );

    cga_sync_edge #(.RESET_VAL(1'b0)) u_vs_sync (
        .clk_i(clock_25), .reset_i(reset), .d_i(vs), .q_o(vs_q), .rise_o(vs_rise)
    );

    assign is_index_s  = (port_a == ADDR_INDEX);
    assign is_data_s   = (port_a == ADDR_DATA);
    assign is_status_s = (port_a == ADDR_STATUS);
    assign port_sel    = is_index_s | is_data_s | is_status_s;

    // Port writes take priority; a read in the same cycle is dropped.
    always_comb begin
        index_d  = index_q;
        regs_d   = regs_q;
        port_o_d = port_o_q;
        if (port_w) begin
            if (is_index_s) begin
                index_d = port_i[4:0];
            end else if (is_data_s) begin
                case (index_q)
                    IDX_CS:  regs_d.cs = port_i[5:0];
                    IDX_CE:  regs_d.ce = port_i[4:0];
                    IDX_CH:  regs_d.ch = port_i[2:0];
                    IDX_CL:  regs_d.cl = port_i;
                    default: regs_d    = regs_q;
                endcase
            end else begin
                regs_d = regs_q;
            end
        end else if (port_r) begin
            if (is_index_s) begin
                port_o_d = {3'b000, index_q};
            end else if (is_data_s) begin
                port_o_d = reg_read(regs_q, index_q);
            end else if (is_status_s) begin
                port_o_d = status_byte(vs_q, hs_q);
            end else begin
                port_o_d = 8'hFF;
            end
        end else begin
            port_o_d = port_o_q;
        end
    end

    // Register file, index and read-data state.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            index_q  <= RST_INDEX;
            regs_q   <= REGS_RESET;
            port_o_q <= RST_PORT_O;
        end else begin
            index_q  <= index_d;
            regs_q   <= regs_d;
            port_o_q <= port_o_d;
        end
    end

`ifdef CRTC_VSYNC_LATCH_EN
    crtc_regs_t out_q, out_d;

    // Registers are shadows; the visible copy is refreshed once per frame.
    always_comb begin
        if (vs_rise) begin
            out_d = regs_q;
        end else begin
            out_d = out_q;
        end
    end

    // Visible cursor state.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            out_q <= REGS_RESET;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_s = out_q;
`else
    logic vs_rise_unused;
    assign vs_rise_unused = vs_rise;
    assign out_s = regs_q;
`endif

    assign port_o          = port_o_q;
    assign cursor          = {out_s.ch, out_s.cl};
    assign cursor_shape_lo = out_s.cs;
    assign cursor_shape_hi = out_s.ce;

endmodule

// File: tb/tb_cga_crtc.sv
// Self-checking bench for cga_crtc: vector table plus a read-data scoreboard.
module tb_cga_crtc;

    logic        clock_25 = 1'b0;
    logic        reset;
    logic [15:0] port_a;
    logic [7:0]  port_i;
    logic        port_w, port_r;
    logic [7:0]  port_o;
    logic        port_sel;
    logic        hs, vs;
    logic [10:0] cursor;
    logic [5:0]  cursor_shape_lo;
    logic [4:0]  cursor_shape_hi;

`ifdef CRTC_VSYNC_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        logic        r;
        logic [7:0]  exp_rd;
        logic        chk_cur;
        logic [10:0] exp_cur;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] rd_q[$];
    logic [7:0] held;
    int         checks = 0;
    int         errors = 0;

    cga_crtc dut (
        .clock_25(clock_25), .reset(reset), .port_a(port_a), .port_i(port_i),
        .port_w(port_w), .port_r(port_r), .port_o(port_o), .port_sel(port_sel),
        .hs(hs), .vs(vs), .cursor(cursor), .cursor_shape_lo(cursor_shape_lo),
        .cursor_shape_hi(cursor_shape_hi)
    );

    always #5 clock_25 = ~clock_25;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [15:0] a, input logic [7:0] d, input logic w,
                                 input logic r, input logic [7:0] e, input logic cc,
                                 input logic [10:0] ec);
        vec_t v;
        v.a = a; v.d = d; v.w = w; v.r = r; v.exp_rd = e; v.chk_cur = cc; v.exp_cur = ec;
        return v;
    endfunction

    // Drive one cycle from a falling edge; check at the next falling edge.
    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w,
                        input logic r, input logic [7:0] e);
        logic exp_sel;
        port_a = a; port_i = d; port_w = w; port_r = r;
        if (r && !w && !reset) rd_q.push_back(e);
        @(negedge clock_25);
        exp_sel = (a == 16'h03D4) || (a == 16'h03D5) || (a == 16'h03DA);
        chk("port_sel", {31'd0, port_sel}, {31'd0, exp_sel});
        if (rd_q.size() != 0) held = rd_q.pop_front();
        chk("port_o", {24'd0, port_o}, {24'd0, held});
        port_w = 1'b0; port_r = 1'b0;
    endtask

    task automatic idle();
        step(16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_outs(input string name, input logic [10:0] c, input logic [5:0] lo,
                            input logic [4:0] hi);
        chk({name, "_cursor"}, {21'd0, cursor}, {21'd0, c});
        chk({name, "_lo"}, {26'd0, cursor_shape_lo}, {26'd0, lo});
        chk({name, "_hi"}, {27'd0, cursor_shape_hi}, {27'd0, hi});
    endtask

    initial begin
        reset = 1'b1; port_a = 16'h0000; port_i = 8'h00; port_w = 1'b0; port_r = 1'b0;
        hs = 1'b1; vs = 1'b0; held = 8'h00;

        tbl.push_back(mkv(16'h03D4, 8'h0A, 1'b1, 1'b0, 8'h00, 1'b1, 11'h000));
        tbl.push_back(mkv(16'h03D5, 8'h00, 1'b0, 1'b1, 8'h0E, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D4, 8'h00, 1'b0, 1'b1, 8'h0A, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D4, 8'h0E, 1'b1, 1'b0, 8'h00, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D5, 8'h07, 1'b1, 1'b0, 8'h00, 1'b1, 11'h700));
        tbl.push_back(mkv(16'h03D4, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D5, 8'hCF, 1'b1, 1'b0, 8'h00, 1'b1, 11'h7CF));
        tbl.push_back(mkv(16'h03D5, 8'h00, 1'b0, 1'b1, 8'hCF, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D4, 8'h0B, 1'b1, 1'b0, 8'h00, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D5, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D5, 8'h00, 1'b0, 1'b1, 8'h1F, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D4, 8'h13, 1'b1, 1'b0, 8'h00, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D5, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 11'h7CF));
        tbl.push_back(mkv(16'h03D5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D6, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h13D4, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D4, 8'hEE, 1'b1, 1'b0, 8'h00, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D4, 8'h00, 1'b0, 1'b1, 8'h0E, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D5, 8'h00, 1'b0, 1'b1, 8'h07, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D4, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 11'h000));
        tbl.push_back(mkv(16'h03D5, 8'h00, 1'b0, 1'b1, 8'hCF, 1'b0, 11'h000));

        repeat (3) @(negedge clock_25);
        chk_outs("reset", 11'h000, 6'd14, 5'd15);
        chk("reset_port_o", {24'd0, port_o}, 32'h00);
        reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].r, tbl[i].exp_rd);
            if (tbl[i].chk_cur)
                chk($sformatf("vec%0d_cursor", i), {21'd0, cursor},
                    {21'd0, (LATCH ? 11'h000 : tbl[i].exp_cur)});
        end

        // Cursor-start write and the frame-boundary update.
        step(16'h03D4, 8'h0A, 1'b1, 1'b0, 8'h00);
        step(16'h03D5, 8'h20, 1'b1, 1'b0, 8'h00);
        chk("lo_after_write", {26'd0, cursor_shape_lo}, LATCH ? 32'd14 : 32'd32);
        step(16'h03D5, 8'h00, 1'b0, 1'b1, 8'h20);
        vs = 1'b1;
        idle();
        chk("lo_at_vs_rise", {26'd0, cursor_shape_lo}, LATCH ? 32'd14 : 32'd32);
        idle();
        chk_outs("after_vs", 11'h7CF, 6'd32, 5'd31);

        // Status port against registered sync levels.
        vs = 1'b1; hs = 1'b1; idle(); idle();
        step(16'h03DA, 8'h00, 1'b0, 1'b1, 8'h09);
        vs = 1'b0; hs = 1'b0; idle(); idle();
        step(16'h03DA, 8'h00, 1'b0, 1'b1, 8'h01);
        vs = 1'b0; hs = 1'b1; idle(); idle();
        step(16'h03DA, 8'h00, 1'b0, 1'b1, 8'h00);

        // Simultaneous write and read: write wins, port_o holds.
        step(16'h03D4, 8'h00, 1'b0, 1'b1, 8'h0A);
        step(16'h03D4, 8'h0E, 1'b1, 1'b1, 8'h00);
        step(16'h03D4, 8'h00, 1'b0, 1'b1, 8'h0E);

        // A strobe during reset is discarded.
        reset = 1'b1;
        held  = 8'h00;
        step(16'h03D4, 8'h0A, 1'b1, 1'b0, 8'h00);
        chk_outs("reset2", 11'h000, 6'd14, 5'd15);
        reset = 1'b0;
        step(16'h03D4, 8'h00, 1'b0, 1'b1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cga_crtc.md
CGA_CRTC -- requirements
Module: cga_crtc

Interface
REQ-001 SHALL have port clock_25, input, 1 bit: sole clock, rising edge; all state changes on it.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port port_a, input, 16 bits: CPU I/O address.
REQ-004 SHALL have port port_i, input, 8 bits: CPU write data.
REQ-005 SHALL have port port_w, input, 1 bit: single-cycle write strobe.
REQ-006 SHALL have port port_r, input, 1 bit: single-cycle read strobe.
REQ-007 SHALL have port port_o, output, 8 bits: registered read data.
REQ-008 SHALL have port port_sel, output, 1 bit: combinational; high while port_a is 0x3D4, 0x3D5 or 0x3DA.
REQ-009 SHALL have port hs, input, 1 bit: horizontal sync from the scan-out stage, low during sync.
REQ-010 SHALL have port vs, input, 1 bit: vertical sync from the scan-out stage, high during sync.
REQ-011 SHALL have port cursor, output, 11 bits: cursor cell index, 0..2047.
REQ-012 SHALL have port cursor_shape_lo, output, 6 bits: first cursor scanline.
REQ-013 SHALL have port cursor_shape_hi, output, 5 bits: last cursor scanline.

Function
REQ-014 Write to 0x3D4 SHALL load index[4:0] from port_i[4:0]; port_i[7:5] are ignored.
REQ-015 Write to 0x3D5 SHALL load the register selected by index: 0x0A R_CS (6 bits), 0x0B R_CE (5 bits), 0x0E R_CH (3 bits), 0x0F R_CL (8 bits); unused port_i bits are dropped; other indices are ignored.
REQ-016 Read SHALL load port_o on the clock edge where port_r=1; data is valid the next cycle and is held until the next read.
REQ-017 Read data: 0x3D4 -> {3'b0,index}; 0x3D5 -> selected register zero-extended, 0x00 for an unimplemented index; 0x3DA -> status; any other address -> 0xFF.
REQ-018 Status SHALL be {4'b0, vs_q, 2'b0, (~hs_q | vs_q)}, where hs_q and vs_q are hs and vs registered once.
REQ-019 port_w and port_r high in the same cycle: the write SHALL execute and the read SHALL be ignored (port_o unchanged).
REQ-020 Outputs SHALL be cursor={R_CH,R_CL}, cursor_shape_lo=R_CS, cursor_shape_hi=R_CE, subject to the update timing in REQ-024.
REQ-021 Setting R_CS bit 5 SHALL hide the cursor, because lo>=32 exceeds every 4-bit scanline; no extra logic is used for this.
REQ-022 A 16-bit port_a SHALL be decoded in full; no aliasing.

Reset
REQ-023 Reset SHALL set index=0, R_CS=0x0E, R_CE=0x0F, R_CH=0, R_CL=0, port_o=0x00, hs_q=1, vs_q=0, and drive the outputs to the same values in the same cycle; a strobe during reset is discarded.

Configuration
REQ-024 With CRTC_VSYNC_LATCH_EN defined, R_* SHALL act as shadows.
- Outputs copy the shadows on the cycle after the rising edge of vs_q.
- A write in that same cycle is picked up at the next frame.
- Readback returns the shadows.
REQ-025 Without CRTC_VSYNC_LATCH_EN, outputs SHALL reflect a 0x3D5 write on the cycle after the write strobe.

Structure
REQ-026 Shared package cga_pkg SHALL hold the port addresses 0x3D4/0x3D5/0x3DA, the register indices 0x0A/0x0B/0x0E/0x0F and the reset values.
REQ-027 One sub-module, cga_sync_edge (input register plus rising-edge pulse), SHALL serve vs_q/hs_q; it is instantiated twice.

Verification
REQ-028 After reset, reading 0x3D5 with index 0x0A SHALL return 0x0E; outputs SHALL be cursor=0, lo=14, hi=15.
REQ-029 Writing 0x0E->0x3D4, 0x07->0x3D5, 0x0F->0x3D4, 0xCF->0x3D5 SHALL give cursor=0x7CF (1999); without the macro it appears 1 cycle after the last write.
REQ-030 With the macro, writing 0x0A=0x20 mid-frame SHALL leave lo unchanged until one cycle after vs rises, then lo=32; readback of 0x0A gives 0x20 immediately.
REQ-031 Holding vs=1, hs=1 SHALL make a 0x3DA read return 0x09; vs=0, hs=0 returns 0x01; vs=0, hs=1 returns 0x00.
REQ-032 Writing 0xFF with index 0x0B SHALL read back 0x1F; writing index 0x13 then 0xAA->0x3D5 SHALL change nothing and read back 0x00; reading 0x3D6 returns 0xFF with port_sel=0.
REQ-033 Simultaneous port_w=port_r=1 at 0x3D4 with 0x0E SHALL update index, and port_o SHALL keep its prior value.
